// File: rtl/fpu_pkg.sv
// Shared FPU widths and port-ID constants used by the shift arbiter and its clients.
package fpu_pkg;
    localparam int MANT_W  = 23;
    localparam int SHAMT_W = 8;

    typedef logic [MANT_W-1:0]  mant_t;
    typedef logic [SHAMT_W-1:0] shamt_t;

    localparam logic SRC_ALIGN = 1'b0;
    localparam logic SRC_NORM  = 1'b1;
endpackage

// File: rtl/fpu_shift_arbiter_if.sv
// Bundle of the two request channels and the result channel of the shared mantissa shifter.
interface fpu_shift_arbiter_if;
    import fpu_pkg::*;

    logic   req0_valid;
    logic   req0_ready;
    mant_t  req0_data;
    shamt_t req0_amt;
    logic   req1_valid;
    logic   req1_ready;
    mant_t  req1_data;
    shamt_t req1_amt;
    logic   out_valid;
    logic   out_ready;
    mant_t  out_data;
    logic   out_sticky;
    logic   out_src;

    // Requesters and the result consumer.
    modport master (
        output req0_valid, req0_data, req0_amt,
        output req1_valid, req1_data, req1_amt,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_data, out_sticky, out_src
    );

    // The shift arbiter itself.
    modport slave (
        input  req0_valid, req0_data, req0_amt,
        input  req1_valid, req1_data, req1_amt,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_data, out_sticky, out_src
    );
endinterface

// File: rtl/fpu_shift_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the port that wins a tie.
//   ptr | meaning
//   0   | port 0 (alignment) wins when both request
//   1   | port 1 (normalisation) wins when both request
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o
);
    logic ptr_q;
    logic ptr_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // After an accepted transfer the port that lost gets the next tie.
    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = gnt_o[0];
        end
    end

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end
endmodule

// File: rtl/fpu_shift_arbiter.sv
// Shared 23-bit mantissa right shifter with round-robin arbitration and a registered result.
// Optional feature: define FPU_SHIFT_STICKY_EN to build the sticky-bit logic (otherwise out_sticky is 0).
module fpu_shift_arbiter
    import fpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    fpu_shift_arbiter_if.slave  bus
);
    localparam shamt_t AMT_SAT = SHAMT_W'(MANT_W);

    logic [1:0] req;
    logic [1:0] gnt;
    logic       slot_free;
    logic       ready0;
    logic       ready1;
    logic       accept;
    mant_t      sel_data;
    shamt_t     sel_amt;
    mant_t      shift_data;
    logic       sticky_c;

    logic       out_valid_q, out_valid_d;
    mant_t      out_data_q,  out_data_d;
    logic       out_sticky_q, out_sticky_d;
    logic       out_src_q,   out_src_d;

    assign req       = {bus.req1_valid, bus.req0_valid};
    assign slot_free = !out_valid_q || bus.out_ready;
    assign ready0    = gnt[0] && slot_free && rst_n;
    assign ready1    = gnt[1] && slot_free && rst_n;
    assign accept    = ready0 || ready1;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (req),
        .adv_i (accept),
        .gnt_o (gnt)
    );

    assign sel_data   = gnt[1] ? bus.req1_data : bus.req0_data;
    assign sel_amt    = gnt[1] ? bus.req1_amt  : bus.req0_amt;
    assign shift_data = (sel_amt >= AMT_SAT) ? '0 : (sel_data >> sel_amt);

`ifdef FPU_SHIFT_STICKY_EN
    mant_t ones;
    mant_t lost_mask;

    // Mask of the bit positions that fall off the bottom of the shifter.
    always_comb begin
        ones      = '1;
        lost_mask = (sel_amt >= AMT_SAT) ? ones : ~(ones << sel_amt);
        sticky_c  = |(sel_data & lost_mask);
    end
`else
    assign sticky_c = 1'b0;
`endif

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sticky_d = out_sticky_q;
        out_src_d    = out_src_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_data_d   = shift_data;
            out_sticky_d = sticky_c;
            out_src_d    = gnt[1] ? SRC_NORM : SRC_ALIGN;
        end else if (bus.out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sticky_q <= 1'b0;
            out_src_q    <= SRC_ALIGN;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sticky_q <= out_sticky_d;
            out_src_q    <= out_src_d;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_sticky = out_sticky_q;
    assign bus.out_src    = out_src_q;
endmodule

// File: tb/tb_fpu_shift_arbiter.sv
// Self-checking bench for fpu_shift_arbiter: directed vector table, corner sequences, random vs reference model.
module tb_fpu_shift_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpu_shift_arbiter_if bus ();

    fpu_shift_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state: round-robin preference and the held result.
    int         m_ptr = 0;
    logic       m_valid = 1'b0;
    logic [22:0] m_data = '0;
    logic       m_sticky = 1'b0;
    logic       m_src = 1'b0;
    logic       acc0, acc1;

`ifdef FPU_SHIFT_STICKY_EN
    localparam bit STICKY_BUILT = 1'b1;
`else
    localparam bit STICKY_BUILT = 1'b0;
`endif

    typedef struct {
        logic [22:0] data;
        logic [7:0]  amt;
        logic [22:0] exp_data;
        logic        exp_sticky;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [22:0] ref_shift(input int d, input int a);
        if (a >= 23) return 23'd0;
        return 23'(d / (1 << a));
    endfunction

    function automatic logic ref_sticky(input int d, input int a);
        int n;
        n = (a < 23) ? a : 23;
        return STICKY_BUILT && ((d % (1 << n)) != 0);
    endfunction

    // One clock: drive at negedge, check readies mid-cycle, check registered outputs after the edge.
    task automatic cycle(input logic rst, input logic v0, input logic [22:0] d0, input logic [7:0] a0,
                         input logic v1, input logic [22:0] d1, input logic [7:0] a1, input logic ordy);
        int  g;
        logic free, e0, e1;
        @(negedge clk);
        rst_n          = rst;
        bus.req0_valid = v0;
        bus.req0_data  = d0;
        bus.req0_amt   = a0;
        bus.req1_valid = v1;
        bus.req1_data  = d1;
        bus.req1_amt   = a1;
        bus.out_ready  = ordy;
        #1;
        free = !m_valid || ordy;
        if (v0 && v1)  g = m_ptr;
        else if (v0)   g = 0;
        else if (v1)   g = 1;
        else           g = -1;
        e0 = rst && free && (g == 0);
        e1 = rst && free && (g == 1);
        chk("req0_ready", bus.req0_ready, e0);
        chk("req1_ready", bus.req1_ready, e1);
        acc0 = e0;
        acc1 = e1;
        @(posedge clk);
        #1;
        if (!rst) begin
            m_ptr = 0; m_valid = 0; m_data = '0; m_sticky = 0; m_src = 0;
        end else if (e0 || e1) begin
            m_valid  = 1'b1;
            m_data   = e0 ? ref_shift(int'(d0), int'(a0)) : ref_shift(int'(d1), int'(a1));
            m_sticky = e0 ? ref_sticky(int'(d0), int'(a0)) : ref_sticky(int'(d1), int'(a1));
            m_src    = e1;
            m_ptr    = e0 ? 1 : 0;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        chk("out_valid", bus.out_valid, m_valid);
        chk("out_data", bus.out_data, m_data);
        chk("out_sticky", bus.out_sticky, m_sticky);
        chk("out_src", bus.out_src, m_src);
    endtask

    initial begin
        logic [22:0] d0r, d1r;
        logic [7:0]  a0r, a1r;
        logic        v0r, v1r;
        int          nres;

        vecs[0] = '{23'h400001, 8'd1,   23'h200000, 1'b1};
        vecs[1] = '{23'h123456, 8'd0,   23'h123456, 1'b0};
        vecs[2] = '{23'h7FFFFF, 8'd23,  23'h000000, 1'b1};
        vecs[3] = '{23'h7FFFFF, 8'd255, 23'h000000, 1'b1};
        vecs[4] = '{23'h400000, 8'd22,  23'h000001, 1'b0};
        vecs[5] = '{23'h123456, 8'd4,   23'h012345, 1'b1};
        vecs[6] = '{23'h000100, 8'd8,   23'h000001, 1'b0};

        bus.req0_valid = 0; bus.req0_data = '0; bus.req0_amt = '0;
        bus.req1_valid = 0; bus.req1_data = '0; bus.req1_amt = '0;
        bus.out_ready  = 0;

        // Reset held 3 cycles with both ports requesting.
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b1, 23'h7FFFFF, 8'd3, 1'b1, 23'h055555, 8'd2, 1'b1);
        cycle(1'b1, 1'b1, 23'h000010, 8'd4, 1'b1, 23'h000020, 8'd1, 1'b1);
        chk("first_grant_src", bus.out_src, 0);
        chk("first_grant_data", bus.out_data, 23'h000001);

        // Directed table, alternating the issuing port.
        for (int i = 0; i < 7; i++) begin
            if (i % 2 == 0)
                cycle(1'b1, 1'b1, vecs[i].data, vecs[i].amt, 1'b0, '0, '0, 1'b1);
            else
                cycle(1'b1, 1'b0, '0, '0, 1'b1, vecs[i].data, vecs[i].amt, 1'b1);
            chk("tbl_data", bus.out_data, vecs[i].exp_data);
            chk("tbl_sticky", bus.out_sticky, STICKY_BUILT && vecs[i].exp_sticky);
            chk("tbl_src", bus.out_src, i % 2);
        end

        // Continuous contention from a fresh reset.
        cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        nres = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 23'(24'h100000 + i), 8'(i), 1'b1, 23'(24'h200000 + i), 8'(i + 1), 1'b1);
            chk("cont_src", bus.out_src, i % 2);
            if (bus.out_valid) nres++;
        end
        chk("cont_results", nres, 8);

        // Backpressure: hold a result, stall 4 cycles, then consume and accept together.
        cycle(1'b1, 1'b1, 23'h3C3C3C, 8'd2, 1'b1, 23'h0F0F0F, 8'd3, 1'b1);
        chk("bp_held_data", bus.out_data, 23'h0F0F0F);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, 23'h3C3C3C, 8'd2, 1'b1, 23'h0F0F0F, 8'd3, 1'b0);
            chk("bp_frozen_data", bus.out_data, 23'h0F0F0F);
            chk("bp_frozen_src", bus.out_src, 0);
        end
        cycle(1'b1, 1'b1, 23'h3C3C3C, 8'd2, 1'b1, 23'h0F0F0F, 8'd3, 1'b1);
        chk("bp_release_accept", acc1, 1);
        chk("bp_release_valid", bus.out_valid, 1);
        chk("bp_release_data", bus.out_data, 23'h01E1E1);

        // Reset while a result is held drops it without a handshake.
        cycle(1'b0, 1'b1, 23'h1, 8'd0, 1'b0, '0, '0, 1'b0);
        chk("rst_drop_valid", bus.out_valid, 0);

        // Randomised traffic with requests held stable until accepted.
        v0r = 0; v1r = 0; d0r = '0; d1r = '0; a0r = '0; a1r = '0;
        for (int i = 0; i < 400; i++) begin
            if (!v0r && ($urandom_range(0, 3) != 0)) begin
                v0r = 1; d0r = 23'($urandom);
                a0r = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 26));
            end
            if (!v1r && ($urandom_range(0, 3) != 0)) begin
                v1r = 1; d1r = 23'($urandom);
                a1r = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 26));
            end
            cycle(($urandom_range(0, 59) != 0), v0r, d0r, a0r, v1r, d1r, a1r, ($urandom_range(0, 3) != 0));
            if (acc0) v0r = 0;
            if (acc1) v1r = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
